seq_divider_32: RTL



---
 rtl/seq_divider_32_pkg.sv | 21 ++
 rtl/BK_Adder_32.sv | 43 ++++
 rtl/seq_divider_32_div_step.sv | 28 ++
 rtl/seq_divider_32.sv | 116 +++++++++++
 4 files changed

// File: rtl/seq_divider_32_pkg.sv
// Shared encodings for the iterative RV32M divider.
package seq_divider_32_pkg;
    localparam int XLEN = 32;
    localparam int ITER = XLEN;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    // op[0]=0 selects the signed forms (DIV/REM).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/BK_Adder_32.sv
// 32-bit Brent-Kung prefix adder: Sum = A + B + Cin, Cout is the carry out of bit 31.
module BK_Adder_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout
);
    logic [31:0] g0, p0, gp, pp;

    always_comb begin
        int step;
        int j;
        g0 = A & B;
        p0 = A ^ B;
        gp = g0;
        pp = p0;
        // Fold Cin into bit 0 so every gp[i] becomes the carry out of bit i.
        gp[0] = g0[0] | (p0[0] & Cin);
        for (int l = 0; l < 5; l++) begin
            step = 1 << l;
            for (int i = 0; i < 32; i++) begin
                if (((i + 1) % (2 * step)) == 0) begin
                    j = i - step;
                    gp[i] = gp[i] | (pp[i] & gp[j[4:0]]);
                    pp[i] = pp[i] & pp[j[4:0]];
                end
            end
        end
        for (int l = 3; l >= 0; l--) begin
            step = 1 << l;
            for (int i = 0; i < 32; i++) begin
                if ((((i + 1) % (2 * step)) == step) && (i + 1 > step)) begin
                    j = i - step;
                    gp[i] = gp[i] | (pp[i] & gp[j[4:0]]);
                    pp[i] = pp[i] & pp[j[4:0]];
                end
            end
        end
        Sum  = p0 ^ {gp[30:0], Cin};
        Cout = gp[31];
    end
endmodule

// File: rtl/seq_divider_32_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step
    import seq_divider_32_pkg::*;
(
    input  logic [XLEN-1:0] r_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] r_o,
    output logic [XLEN-1:0] q_o
);
    logic [XLEN-1:0] shifted, diff;
    logic            cout, take;

    assign shifted = {r_i[XLEN-2:0], q_i[XLEN-1]};

    BK_Adder_32 u_sub (
        .A   (shifted),
        .B   (~dvs_i),
        .Cin (1'b1),
        .Sum (diff),
        .Cout(cout)
    );

    // r_i[31] is the implicit 33rd partial-remainder bit, so the subtract always fits.
    assign take = r_i[XLEN-1] | cout;
    assign r_o  = take ? diff : shifted;
    assign q_o  = {q_i[XLEN-2:0], take};
endmodule

// File: rtl/seq_divider_32.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
module seq_divider_32
    import seq_divider_32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);
    state_t          state_q;
    logic [4:0]      cnt_q;
    logic [1:0]      op_q;
    logic            q_neg_q, r_neg_q;
    logic [XLEN-1:0] r_q, q_q, dvs_q;
    logic            busy_q, done_q, dbz_q;
    logic [XLEN-1:0] res_q, quo_q, rem_q;

    logic            sgn, dvd_neg, dvs_neg, dvs_zero;
    logic [XLEN-1:0] neg_a_in, neg_b_in, neg_a, neg_b;
    logic [XLEN-1:0] abs_dvd, abs_dvs, q_fix, r_fix, r_d, q_d;
    logic            unused_co_a, unused_co_b;

    assign sgn      = is_signed_op(op);
    assign dvd_neg  = sgn & dividend[XLEN-1];
    assign dvs_neg  = sgn & divisor[XLEN-1];
    assign dvs_zero = (divisor == '0);

    // The two negators take the operands in IDLE and the raw results in FIX.
    assign neg_a_in = (state_q == FIX) ? q_q : dividend;
    assign neg_b_in = (state_q == FIX) ? r_q : divisor;

    BK_Adder_32 u_neg_a (.A('0), .B(~neg_a_in), .Cin(1'b1), .Sum(neg_a), .Cout(unused_co_a));
    BK_Adder_32 u_neg_b (.A('0), .B(~neg_b_in), .Cin(1'b1), .Sum(neg_b), .Cout(unused_co_b));

    // |0x80000000| stays 0x80000000, which is correct when read as unsigned.
    assign abs_dvd = dvd_neg ? neg_a : dividend;
    assign abs_dvs = dvs_neg ? neg_b : divisor;
    assign q_fix   = q_neg_q ? neg_a : q_q;
    assign r_fix   = r_neg_q ? neg_b : r_q;

    div_step u_step (
        .r_i  (r_q),
        .q_i  (q_q),
        .dvs_i(dvs_q),
        .r_o  (r_d),
        .q_o  (q_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            res_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        // Divide by zero must leave the all-ones quotient un-negated.
                        q_neg_q <= (dvd_neg ^ dvs_neg) & ~dvs_zero;
                        r_neg_q <= dvd_neg;
                        dbz_q   <= dvs_zero;
                        q_q     <= abs_dvd;
                        dvs_q   <= abs_dvs;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(ITER - 1)) state_q <= FIX;
                end
                FIX: begin
                    quo_q   <= q_fix;
                    rem_q   <= r_fix;
                    res_q   <= op_q[1] ? r_fix : q_fix;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = res_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule
